// File: rtl/hs_pkg.sv
// ----------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the four-phase handshake channel arbiter:
//   - hs_state_t   : handshake FSM state encoding
//   - HS_TIMEOUT_W : width of the REQ_HI timeout counter
//   - rr_pick()    : round-robin search of a pending vector
// ----------------------------------------------------------------------------
package hs_pkg;

    localparam int unsigned HS_TIMEOUT_W = 16;
    localparam int unsigned HS_MAX_REQ   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } hs_state_t;

    // Returns the first set index of pending[n-1:0] searching upward from
    // ptr+1 and wrapping modulo n. Returns ptr when nothing is pending; the
    // caller qualifies the result with |pending.
    function automatic int unsigned rr_pick(input logic [HS_MAX_REQ-1:0] pending,
                                            input int unsigned           ptr,
                                            input int unsigned           n);
        int unsigned idx;
        int unsigned result;
        logic        found;
        result = ptr;
        found  = 1'b0;
        for (int unsigned k = 1; k <= HS_MAX_REQ; k++) begin
            if (k <= n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && pending[idx]) begin
                    result = idx;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// ----------------------------------------------------------------------------
// cdc_sync_bit
// Multi-flop synchroniser for a single asynchronous level.
// Ports:
//   clk_f : destination clock
//   rst   : synchronous, active-high reset (chain cleared to 0)
//   d     : asynchronous input level
//   q     : synchronised level (last flop of the chain)
// ----------------------------------------------------------------------------
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_f,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_f) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hs_chan_arbiter.sv
// ----------------------------------------------------------------------------
// hs_chan_arbiter
// Shares one four-phase req/ack crossing between N_REQ event sources.
// Events are latched as sticky pending bits, granted round-robin, and each
// grant runs a full return-to-zero handshake against the slow-domain ack.
// Ports:
//   clk_f       : fast clock (only clock of the block)
//   rst         : synchronous, active-high reset
//   evt_in      : per-requester single-cycle event pulses
//   req_out     : registered handshake request to the slow domain
//   id_out      : granted requester, stable while a handshake is in flight
//   ack_in      : asynchronous ack from the slow domain
//   busy        : high whenever the FSM is not IDLE
//   done        : one-cycle pulse when ack is seen high
//   done_id     : ID of the completed handshake, valid with done
//   ovf         : one-cycle pulse per requester when an event is dropped
//   timeout_err : one-cycle pulse when a handshake is aborted in REQ_HI
// ----------------------------------------------------------------------------
module hs_chan_arbiter
    import hs_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ID_W        = $clog2(N_REQ),
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk_f,
    input  logic             rst,
    input  logic [N_REQ-1:0] evt_in,
    output logic             req_out,
    output logic [ID_W-1:0]  id_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [N_REQ-1:0] ovf,
    output logic             timeout_err
);

    hs_state_t               state;
    logic [N_REQ-1:0]        pending;
    logic [ID_W-1:0]         ptr;
    logic [HS_TIMEOUT_W-1:0] cnt;
    logic                    ack_s;

    logic [HS_MAX_REQ-1:0]   pend_ext;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [N_REQ-1:0]        grant_mask;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_f (clk_f),
        .rst   (rst),
        .d     (ack_in),
        .q     (ack_s)
    );

    // Grant decision is purely a function of registered state.
    always_comb begin
        pend_ext              = '0;
        pend_ext[N_REQ-1:0]   = pending;
        grant_vld             = (state == IDLE) && (|pending);
        grant_id              = ID_W'(rr_pick(pend_ext, 32'(ptr), N_REQ));
        grant_mask            = '0;
        if (grant_vld) begin
            grant_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    // An event on the grant cycle re-arms the bit (set wins, no overflow).
    always_ff @(posedge clk_f) begin
        if (rst) begin
            pending <= '0;
            ovf     <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | evt_in;
            ovf     <= evt_in & pending & ~grant_mask;
        end
    end

    always_ff @(posedge clk_f) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= ID_W'(N_REQ - 1);
            cnt         <= '0;
            req_out     <= 1'b0;
            id_out      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= '0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        id_out  <= grant_id;
                        ptr     <= grant_id;
                        req_out <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        done    <= 1'b1;
                        done_id <= id_out;
                        cnt     <= '0;
                        state   <= REQ_LO;
                    end else if (cnt == HS_TIMEOUT_W'(TIMEOUT - 1)) begin
                        req_out     <= 1'b0;
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= REQ_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_chan_arbiter.sv
// ----------------------------------------------------------------------------
// tb_hs_chan_arbiter
// Directed bench for hs_chan_arbiter. u0 (TIMEOUT=255) carries the
// arbitration/handshake scenarios with a hand-driven slow-side ack; u1
// (TIMEOUT=8, ack tied low) carries the abort scenario.
// ----------------------------------------------------------------------------
module tb_hs_chan_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clk_f = 1'b0;
    logic          rst;
    logic [N-1:0]  evt0, evt1;
    logic          ack0, ack1;

    logic          req0, busy0, done0, tmo0;
    logic [IW-1:0] id0, did0;
    logic [N-1:0]  ovf0;
    logic          req1, busy1, done1, tmo1;
    logic [IW-1:0] id1, did1;
    logic [N-1:0]  ovf1;

    int n_chk  = 0;
    int n_pass = 0;

    int ovf_cnt [N];
    int done1_cnt = 0;

    always #5 clk_f = ~clk_f;

    hs_chan_arbiter #(
        .N_REQ       (N),
        .ID_W        (IW),
        .SYNC_STAGES (2),
        .TIMEOUT     (255)
    ) u0 (
        .clk_f       (clk_f),
        .rst         (rst),
        .evt_in      (evt0),
        .req_out     (req0),
        .id_out      (id0),
        .ack_in      (ack0),
        .busy        (busy0),
        .done        (done0),
        .done_id     (did0),
        .ovf         (ovf0),
        .timeout_err (tmo0)
    );

    hs_chan_arbiter #(
        .N_REQ       (N),
        .ID_W        (IW),
        .SYNC_STAGES (2),
        .TIMEOUT     (8)
    ) u1 (
        .clk_f       (clk_f),
        .rst         (rst),
        .evt_in      (evt1),
        .req_out     (req1),
        .id_out      (id1),
        .ack_in      (ack1),
        .busy        (busy1),
        .done        (done1),
        .done_id     (did1),
        .ovf         (ovf1),
        .timeout_err (tmo1)
    );

    initial begin
        for (int i = 0; i < N; i++) ovf_cnt[i] = 0;
    end

    always @(negedge clk_f) begin
        for (int i = 0; i < N; i++) begin
            if (ovf0[i] === 1'b1) ovf_cnt[i] = ovf_cnt[i] + 1;
        end
        if (done1 === 1'b1) done1_cnt = done1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    task automatic pulse0(input logic [N-1:0] v);
        evt0 = v;
        step();
        evt0 = '0;
    endtask

    // Waits (bounded) for u0 to raise req and checks the granted ID.
    task automatic wait_req(input string tag, input logic [IW-1:0] exp_id);
        for (int i = 0; i < 20 && !req0; i++) step();
        check({tag, "_req"}, 32'(req0), 32'd1);
        check({tag, "_id"}, 32'(id0), 32'(exp_id));
    endtask

    // Slow side: hold ack low for 'delay' cycles, raise it, wait for done,
    // drop it, wait for return to IDLE. Returns cycles from ack to done.
    task automatic complete(input string tag, input int delay,
                            input logic [IW-1:0] exp_id, output int ack_lat);
        for (int i = 0; i < delay; i++) begin
            step();
            check({tag, "_hold_req"}, 32'(req0), 32'd1);
            check({tag, "_hold_id"}, 32'(id0), 32'(exp_id));
        end
        ack0    = 1'b1;
        ack_lat = 0;
        for (int i = 0; i < 10 && !done0; i++) begin
            step();
            ack_lat++;
        end
        check({tag, "_done"}, 32'(done0), 32'd1);
        check({tag, "_done_id"}, 32'(did0), 32'(exp_id));
        check({tag, "_req_drop"}, 32'(req0), 32'd0);
        ack0 = 1'b0;
        for (int i = 0; i < 10 && busy0; i++) step();
        check({tag, "_idle"}, 32'(busy0), 32'd0);
        check({tag, "_idle_req"}, 32'(req0), 32'd0);
        check({tag, "_id_held"}, 32'(id0), 32'(exp_id));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int ovf_base [N];

        rst  = 1'b1;
        evt0 = '0;
        evt1 = '0;
        ack0 = 1'b0;
        ack1 = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_req", 32'(req0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_id", 32'(id0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_tmo", 32'(tmo0), 32'd0);

        // Simultaneous events from reset: requester 0 first, then 1, then 3
        pulse0(4'b1011);
        wait_req("sim0", 2'd0);
        complete("sim0", 1, 2'd0, lat);
        check("sim_gap0", 32'(req0), 32'd0);
        wait_req("sim1", 2'd1);
        complete("sim1", 1, 2'd1, lat);
        check("sim_gap1", 32'(req0), 32'd0);
        wait_req("sim3", 2'd3);
        complete("sim3", 1, 2'd3, lat);
        step();
        step();
        check("sim_no_more", 32'(req0), 32'd0);

        // Single event: exact latency, ack 6 cycles after req
        evt0 = 4'b0100;
        step();
        evt0 = '0;
        check("single_t1_req", 32'(req0), 32'd0);
        step();
        check("single_t2_req", 32'(req0), 32'd1);
        check("single_t2_id", 32'(id0), 32'd2);
        check("single_busy", 32'(busy0), 32'd1);
        complete("single", 6, 2'd2, lat);
        check("single_ack_lat", 32'(lat), 32'd3);

        // Coalesce: two events on 1 while busy with 0 -> one ovf, one grant
        for (int i = 0; i < N; i++) ovf_base[i] = ovf_cnt[i];
        pulse0(4'b0001);
        wait_req("coal0", 2'd0);
        pulse0(4'b0010);
        step();
        pulse0(4'b0010);
        step();
        complete("coal0", 2, 2'd0, lat);
        wait_req("coal1", 2'd1);
        complete("coal1", 2, 2'd1, lat);
        for (int i = 0; i < 5; i++) step();
        check("coal_no_regrant", 32'(req0), 32'd0);
        check("coal_ovf1", 32'(ovf_cnt[1] - ovf_base[1]), 32'd1);
        check("coal_ovf0", 32'(ovf_cnt[0] - ovf_base[0]), 32'd0);

        // Event on the grant edge: set wins, no ovf, second handshake for 2
        for (int i = 0; i < N; i++) ovf_base[i] = ovf_cnt[i];
        evt0 = 4'b0100;
        step();
        step();
        evt0 = '0;
        check("gedge_req", 32'(req0), 32'd1);
        wait_req("gedge_a", 2'd2);
        complete("gedge_a", 1, 2'd2, lat);
        wait_req("gedge_b", 2'd2);
        complete("gedge_b", 1, 2'd2, lat);
        check("gedge_ovf2", 32'(ovf_cnt[2] - ovf_base[2]), 32'd0);

        // Timeout on u1 (TIMEOUT=8, ack held low)
        evt1 = 4'b0001;
        step();
        evt1 = '0;
        for (int i = 0; i < 20 && !req1; i++) step();
        check("tmo_req", 32'(req1), 32'd1);
        n = 0;
        while (req1 && n < 20) begin
            step();
            n++;
        end
        check("tmo_hi_cycles", 32'(n), 32'd8);
        check("tmo_pulse", 32'(tmo1), 32'd1);
        check("tmo_no_done", 32'(done1_cnt), 32'd0);
        step();
        check("tmo_pulse_end", 32'(tmo1), 32'd0);
        check("tmo_idle", 32'(busy1), 32'd0);

        // Reset during REQ_HI with another event pending
        pulse0(4'b0010);
        wait_req("rmid", 2'd1);
        pulse0(4'b0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmid_req", 32'(req0), 32'd0);
        check("rmid_busy", 32'(busy0), 32'd0);
        check("rmid_id", 32'(id0), 32'd0);
        check("rmid_done", 32'(done0), 32'd0);
        check("rmid_tmo", 32'(tmo0), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("rmid_pend_clr", 32'(req0), 32'd0);
        pulse0(4'b1000);
        wait_req("rmid3", 2'd3);
        complete("rmid3", 2, 2'd3, lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hs_chan_arbiter.md
Name: hs_chan_arbiter

Overview:
- Fast-domain controller that shares one 1-bit four-phase req/ack crossing between N_REQ pulse sources.
- Each source raises single-cycle event pulses. The block latches them as sticky pending bits and grants the channel round-robin.
- For each grant it drives req_out with a stable requester ID, then completes the full return-to-zero handshake against the slow-domain ack.
- It sits on the clk_f side, directly in front of the slow-domain req sampler and ack driver.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of the granted-ID bus.
- SYNC_STAGES, 2, flop stages on ack_in (minimum 2).
- TIMEOUT, 255, max clk_f cycles in REQ_HI before abort (1..65535); the counter is 16 bits wide.

Ports:
- clk_f  in  1  fast clock; the only clock of the block.
- rst  in  1  synchronous, active-high reset.
- evt_in  in  N_REQ  per-requester single-cycle event pulses.
- req_out  out  1  handshake request to slow domain; registered, glitch-free.
- id_out  out  ID_W  granted requester; stable while a handshake is in flight.
- ack_in  in  1  asynchronous ack from slow domain.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when ack is seen high.
- done_id  out  ID_W  ID of the completed handshake; valid with done.
- ovf  out  N_REQ  one-cycle pulse per requester when an event is dropped.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values: all outputs 0, pending = 0, RR pointer = N_REQ-1 (so requester 0 has priority first), sync chain = 0, state = IDLE, timeout counter = 0.
- Reset mid-handshake drops req_out on the next edge; no done or timeout_err is generated.
- Ack synchronisation: ack_s is the last stage of a SYNC_STAGES flop chain on ack_in. No other logic touches ack_in.
- Pending, per bit i:
  - set on evt_in[i];
  - cleared when i is granted;
  - set wins when an event and a grant for i fall on the same cycle, with no ovf.
  - An event with pending[i] already set and not being granted pulses ovf[i] one cycle later. The pending state is unchanged (events coalesce).
- Arbitration (IDLE only):
  - Search pending from ptr+1 upward, wrapping modulo N_REQ.
  - First hit g: id_out <= g, ptr <= g, req_out <= 1, clear pending[g], go to REQ_HI, all on one edge.
  - No pending bits: stay in IDLE.
- Latency: evt_in at edge t, channel idle -> pending at t+1 -> req_out high after edge t+2.
- REQ_HI:
  - req_out held at 1; the counter increments each cycle.
  - ack_s == 1: req_out <= 0, done pulse, done_id = id_out, counter cleared, go to REQ_LO.
  - Counter reaches TIMEOUT before ack_s: req_out <= 0, timeout_err pulse, no done, go to REQ_LO. The event is lost and reported.
- REQ_LO:
  - Wait for ack_s == 0, then go to IDLE. There is no timeout: the channel is never reused before return to zero.
  - id_out stays held until IDLE is reached.
- IDLE lasts at least one cycle between handshakes; the next grant is made in that cycle.
- ack_s high while in IDLE is ignored.
- Events arriving during any state are only accumulated in pending; they are never lost except as ovf.
- No combinational path from any input to any output.

Decomposition:
- Shared package hs_pkg: state enum (IDLE, REQ_HI, REQ_LO), HS_TIMEOUT_W = 16, function rr_pick(pending, ptr) returning the next index.
- One sub-module: cdc_sync_bit (parameter STAGES, ports clk_f, rst, d, q). It is reused by the slow-domain side for req.

Test Plan:
- Single event: evt_in=4'b0100 for 1 cycle, ack returns 6 cycles after req -> req_out high at t+2, id_out=2, done with done_id=2 when ack_s=1, busy low once ack is back to 0.
- Simultaneous events: evt_in=4'b1011 in one cycle, prompt ack -> grants in order 0, 1, 3, each separated by REQ_LO->IDLE; id_out never changes while req_out=1.
- Coalesce/overflow: two pulses on evt_in[1] while channel busy with ID 0 -> exactly one ovf[1] pulse, exactly one later grant of ID 1.
- Event on grant edge: evt_in[2] pulses in the same cycle pending[2] is granted -> no ovf, second handshake with ID 2 follows.
- Timeout: TIMEOUT=8, ack_in held 0 -> req_out drops after 8 REQ_HI cycles, timeout_err one pulse, no done, return to IDLE.
- Reset mid-op: rst for 1 cycle during REQ_HI -> req_out, busy, pending and id_out all 0 at the next edge; the next evt_in[3] is granted normally (pointer back to N_REQ-1).
